// File: rtl/instr_register_pkg.sv
// Shared types and constants for the instruction-register family.
//   opcode_t   : instruction opcode, ZERO first so an all-zero word decodes as ZERO
//   zero_word  : all-zero instruction bits, wide enough for any supported operand width
package instr_register_pkg;

   localparam int unsigned DEFAULT_DEPTH = 32;
   localparam int unsigned DEFAULT_OP_W  = 32;
   localparam int unsigned OPC_W         = 3;
   localparam int unsigned MAX_OP_W      = 64;
   localparam int unsigned MAX_WORD_W    = OPC_W + 2 * MAX_OP_W;

   typedef enum logic [OPC_W-1:0] {
      ZERO,
      PASSA,
      PASSB,
      ADD,
      SUB,
      MULT,
      DIV,
      MOD
   } opcode_t;

   // Modules keep the low {opc, op_a, op_b} bits for their own operand width.
   function automatic logic [MAX_WORD_W-1:0] zero_word();
      return '0;
   endfunction

endpackage

// File: rtl/instr_buffer_ptr.sv
// Wrap-around head/tail pointers and occupancy counter for the FIFO view of instr_buffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous flush of pointers and count
//   push, pop    : already-qualified accepts (caller guarantees no push when full, no pop when empty)
//   head, tail   : read / write pointers, wrap modulo DEPTH
//   count        : occupancy 0..DEPTH
module instr_buffer_ptr #(
   parameter int unsigned DEPTH = 32,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   output logic [AW-1:0] head,
   output logic [AW-1:0] tail,
   output logic [AW:0]   count
);

   // DEPTH is a power of two, so plain overflow gives the modulo wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/instr_buffer.sv
// Instruction storage: DEPTH words of {opc, op_a, op_b}, random-access or FIFO.
//   clk, reset_n        : clock, asynchronous active-low reset
//   clear               : synchronous flush of valid bits / pointers / count
//   wr_valid, wr_ready  : write handshake; wr_addr used only in random mode
//   opcode, operand_a/b : write data
//   rd_req, rd_addr     : read (random) or pop (FIFO); rd_addr used only in random mode
//   rd_valid            : one-cycle pulse when instruction_word was loaded by a read
//   entry_valid         : valid bit of the entry read (FIFO: same as rd_valid)
//   instruction_word    : registered {opc, op_a, op_b}, holds between reads
//   count, full, empty  : occupancy and flags
module instr_buffer
   import instr_register_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   parameter int unsigned OP_W = DEFAULT_OP_W,
   parameter bit FIFO_MODE = 1'b0,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned INSTR_W = OPC_W + 2 * OP_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [AW-1:0]        wr_addr,
   input  opcode_t              opcode,
   input  logic signed [OP_W-1:0] operand_a,
   input  logic signed [OP_W-1:0] operand_b,
   input  logic                 rd_req,
   input  logic [AW-1:0]        rd_addr,
   output logic                 rd_valid,
   output logic                 entry_valid,
   output logic [INSTR_W-1:0]   instruction_word,
   output logic [AW:0]          count,
   output logic                 full,
   output logic                 empty
);

   typedef struct packed {
      opcode_t                opc;
      logic signed [OP_W-1:0] op_a;
      logic signed [OP_W-1:0] op_b;
   } instr_t;

   localparam logic [MAX_WORD_W-1:0] ZERO_BITS = zero_word();
   localparam instr_t ZERO_INSTR = instr_t'(ZERO_BITS[INSTR_W-1:0]);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   instr_t          mem [DEPTH];
   logic [DEPTH-1:0] valid;
   instr_t          word;
   instr_t          wdata;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [AW-1:0]   waddr;
   logic            wr_fire;
   logic            pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign wr_ready = FIFO_MODE ? !full : 1'b1;

   assign wr_fire = wr_valid && wr_ready;
   assign pop     = FIFO_MODE && rd_req && !empty;
   assign waddr   = FIFO_MODE ? tail : wr_addr;
   assign wdata   = '{opc: opcode, op_a: operand_a, op_b: operand_b};

   assign instruction_word = word;

   if (FIFO_MODE) begin : g_fifo
      instr_buffer_ptr #(
         .DEPTH (DEPTH)
      ) u_ptr (
         .clk     (clk),
         .reset_n (reset_n),
         .clear   (clear),
         .push    (wr_fire),
         .pop     (pop),
         .head    (head),
         .tail    (tail),
         .count   (count)
      );
   end else begin : g_rand
      assign head = '0;
      assign tail = '0;

      // Count follows valid-bit transitions: only a write to an invalid entry adds one.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            count <= '0;
         end else if (clear) begin
            count <= '0;
         end else if (wr_fire && !valid[wr_addr]) begin
            count <= count + 1'b1;
         end
      end
   end

   // Storage; clear leaves data untouched but still blocks the same-cycle write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= ZERO_INSTR;
         valid <= '0;
      end else if (clear) begin
         valid <= '0;
      end else if (wr_fire) begin
         mem[waddr] <= wdata;
         if (!FIFO_MODE) valid[waddr] <= 1'b1;
      end
   end

   // Registered read port; mem is sampled before the same-edge write lands, so a
   // colliding read returns the old contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word        <= ZERO_INSTR;
         rd_valid    <= 1'b0;
         entry_valid <= 1'b0;
      end else if (clear) begin
         rd_valid    <= 1'b0;
         entry_valid <= 1'b0;
      end else if (FIFO_MODE) begin
         rd_valid    <= pop;
         entry_valid <= pop;
         if (pop) word <= mem[head];
      end else begin
         rd_valid    <= rd_req;
         entry_valid <= rd_req && valid[rd_addr];
         if (rd_req) word <= valid[rd_addr] ? mem[rd_addr] : ZERO_INSTR;
      end
   end

endmodule

// File: tb/tb_instr_buffer.sv
module tb_instr_buffer;
   import instr_register_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [66:0] w32(input opcode_t o, input int a, input int b);
      return {o, a, b};
   endfunction

   function automatic logic [34:0] w16(input opcode_t o, input shortint a, input shortint b);
      return {o, a, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // FIFO instance, DEPTH=4
   logic        f_clear = 0, f_wr_valid = 0, f_rd_req = 0;
   logic        f_wr_ready, f_rd_valid, f_entry_valid, f_full, f_empty;
   opcode_t     f_opc = ZERO;
   logic signed [31:0] f_a = 0, f_b = 0;
   logic [66:0] f_word;
   logic [2:0]  f_count;

   instr_buffer #(.DEPTH(4), .OP_W(32), .FIFO_MODE(1'b1)) u_fifo (
      .clk (clk), .reset_n (reset_n), .clear (f_clear),
      .wr_valid (f_wr_valid), .wr_ready (f_wr_ready), .wr_addr (2'd0),
      .opcode (f_opc), .operand_a (f_a), .operand_b (f_b),
      .rd_req (f_rd_req), .rd_addr (2'd0), .rd_valid (f_rd_valid),
      .entry_valid (f_entry_valid), .instruction_word (f_word),
      .count (f_count), .full (f_full), .empty (f_empty)
   );

   // Random-access instance, DEPTH=32
   logic        r_clear = 0, r_wr_valid = 0, r_rd_req = 0;
   logic        r_wr_ready, r_rd_valid, r_entry_valid, r_full, r_empty;
   logic [4:0]  r_wr_addr = 0, r_rd_addr = 0;
   opcode_t     r_opc = ZERO;
   logic signed [31:0] r_a = 0, r_b = 0;
   logic [66:0] r_word;
   logic [5:0]  r_count;

   instr_buffer #(.DEPTH(32), .OP_W(32), .FIFO_MODE(1'b0)) u_rand (
      .clk (clk), .reset_n (reset_n), .clear (r_clear),
      .wr_valid (r_wr_valid), .wr_ready (r_wr_ready), .wr_addr (r_wr_addr),
      .opcode (r_opc), .operand_a (r_a), .operand_b (r_b),
      .rd_req (r_rd_req), .rd_addr (r_rd_addr), .rd_valid (r_rd_valid),
      .entry_valid (r_entry_valid), .instruction_word (r_word),
      .count (r_count), .full (r_full), .empty (r_empty)
   );

   // Random-access instance, OP_W=16
   logic        s_wr_valid = 0, s_rd_req = 0;
   logic        s_wr_ready, s_rd_valid, s_entry_valid, s_full, s_empty;
   logic [2:0]  s_addr = 0;
   opcode_t     s_opc = ZERO;
   logic signed [15:0] s_a = 0, s_b = 0;
   logic [34:0] s_word;
   logic [3:0]  s_count;

   instr_buffer #(.DEPTH(8), .OP_W(16), .FIFO_MODE(1'b0)) u_narrow (
      .clk (clk), .reset_n (reset_n), .clear (1'b0),
      .wr_valid (s_wr_valid), .wr_ready (s_wr_ready), .wr_addr (s_addr),
      .opcode (s_opc), .operand_a (s_a), .operand_b (s_b),
      .rd_req (s_rd_req), .rd_addr (s_addr), .rd_valid (s_rd_valid),
      .entry_valid (s_entry_valid), .instruction_word (s_word),
      .count (s_count), .full (s_full), .empty (s_empty)
   );

   task automatic f_set(input logic wv, input opcode_t o, input int a, input int b,
                        input logic rr);
      f_wr_valid = wv;
      f_opc = o;
      f_a = a;
      f_b = b;
      f_rd_req = rr;
   endtask

   task automatic f_pop_check(input string tag, input logic [66:0] exp);
      f_set(0, ZERO, 0, 0, 1);
      tick();
      check({tag, "_word"}, f_word, exp);
      check({tag, "_rv"}, f_rd_valid, 1'b1);
      f_rd_req = 0;
   endtask

   task automatic r_op(input logic wv, input int wa, input opcode_t o, input int a, input int b,
                       input logic rr, input int ra);
      r_wr_valid = wv;
      r_wr_addr = 5'(wa);
      r_opc = o;
      r_a = a;
      r_b = b;
      r_rd_req = rr;
      r_rd_addr = 5'(ra);
      tick();
      r_wr_valid = 0;
      r_rd_req = 0;
   endtask

   opcode_t     push_opc [4] = '{ADD, SUB, MULT, DIV};

   initial begin
      tick();
      tick();
      reset_n = 1;
      tick();

      // Reset state
      check("rst_f_count", f_count, 0);
      check("rst_f_empty", f_empty, 1);
      check("rst_f_full", f_full, 0);
      check("rst_f_rv", f_rd_valid, 0);
      check("rst_f_word", f_word, 0);

      // FIFO fill to full
      for (int i = 0; i < 4; i++) begin
         f_set(1, push_opc[i], 2 * i + 1, 2 * i + 2, 0);
         tick();
      end
      check("fill_count", f_count, 4);
      check("fill_full", f_full, 1);
      check("fill_wr_ready", f_wr_ready, 0);
      f_set(1, MOD, 9, 9, 0);
      tick();
      check("drop5_count", f_count, 4);
      f_set(0, ZERO, 0, 0, 0);

      // Drain in order
      f_pop_check("pop0", w32(ADD, 1, 2));
      f_pop_check("pop1", w32(SUB, 3, 4));
      f_pop_check("pop2", w32(MULT, 5, 6));
      f_pop_check("pop3", w32(DIV, 7, 8));
      check("drain_empty", f_empty, 1);
      check("drain_count", f_count, 0);
      tick();
      check("pulse_rv", f_rd_valid, 0);

      // Pop while empty is ignored, word holds
      f_set(0, ZERO, 0, 0, 1);
      tick();
      check("pop_empty_rv", f_rd_valid, 0);
      check("pop_empty_hold", f_word, w32(DIV, 7, 8));

      // Push with pop on empty: no bypass
      f_set(1, PASSA, 11, 12, 1);
      tick();
      check("nobyp_rv", f_rd_valid, 0);
      check("nobyp_count", f_count, 1);
      f_pop_check("nobyp_pop", w32(PASSA, 11, 12));

      // Wrap-around: push 3, pop 2, push 3
      for (int i = 3; i <= 5; i++) begin
         f_set(1, ADD, i, -i, 0);
         tick();
      end
      f_pop_check("wrap_pop3", w32(ADD, 3, -3));
      f_pop_check("wrap_pop4", w32(ADD, 4, -4));
      for (int i = 6; i <= 8; i++) begin
         f_set(1, SUB, i, -i, 0);
         tick();
      end
      f_set(0, ZERO, 0, 0, 0);
      check("wrap_count", f_count, 4);
      f_pop_check("wrap_pop5", w32(ADD, 5, -5));
      f_pop_check("wrap_pop6", w32(SUB, 6, -6));
      f_pop_check("wrap_pop7", w32(SUB, 7, -7));

      // Push and pop together at count=2
      f_set(1, MOD, 20, 21, 0);
      tick();
      check("sim_pre_count", f_count, 2);
      f_set(1, MOD, 22, 23, 1);
      tick();
      check("sim_count", f_count, 2);
      check("sim_word", f_word, w32(SUB, 8, -8));

      // Full: pop proceeds, push refused
      f_set(1, PASSB, 24, 25, 0);
      tick();
      f_set(1, PASSB, 26, 27, 0);
      tick();
      check("full2_full", f_full, 1);
      f_set(1, DIV, 99, 99, 1);
      tick();
      check("fullpp_count", f_count, 3);
      check("fullpp_word", f_word, w32(MOD, 20, 21));
      f_set(0, ZERO, 0, 0, 0);

      // Clear together with a push
      f_clear = 1;
      f_set(1, ADD, 50, 51, 1);
      tick();
      f_clear = 0;
      f_set(0, ZERO, 0, 0, 0);
      check("clr_count", f_count, 0);
      check("clr_empty", f_empty, 1);
      check("clr_rv", f_rd_valid, 0);
      f_set(0, ZERO, 0, 0, 1);
      tick();
      check("clr_lost_rv", f_rd_valid, 0);
      f_rd_req = 0;

      // Random mode
      check("rnd_wr_ready", r_wr_ready, 1);
      r_op(1, 5, ADD, -5, 9, 0, 0);
      r_op(0, 0, ZERO, 0, 0, 1, 5);
      check("rnd_rd5_word", r_word, w32(ADD, -5, 9));
      check("rnd_rd5_ev", r_entry_valid, 1);
      check("rnd_rd5_rv", r_rd_valid, 1);
      check("rnd_count1", r_count, 1);
      r_op(0, 0, ZERO, 0, 0, 1, 6);
      check("rnd_rd6_word", r_word, 0);
      check("rnd_rd6_ev", r_entry_valid, 0);
      check("rnd_rd6_rv", r_rd_valid, 1);
      r_op(1, 5, SUB, 1, 1, 1, 5);
      check("rnd_coll_word", r_word, w32(ADD, -5, 9));
      check("rnd_rewr_count", r_count, 1);
      r_op(0, 0, ZERO, 0, 0, 1, 5);
      check("rnd_new_word", r_word, w32(SUB, 1, 1));
      r_op(0, 0, ZERO, 0, 0, 1, 5);
      check("rnd_read_keeps_valid", r_entry_valid, 1);
      r_op(1, 31, MOD, 7, -7, 0, 0);
      check("rnd_count2", r_count, 2);

      // Random clear with a write: valid bits gone, write lost
      r_clear = 1;
      r_op(1, 3, PASSA, 4, 4, 0, 0);
      r_clear = 0;
      check("rnd_clr_count", r_count, 0);
      check("rnd_clr_empty", r_empty, 1);
      r_op(0, 0, ZERO, 0, 0, 1, 5);
      check("rnd_clr_ev", r_entry_valid, 0);
      check("rnd_clr_word", r_word, 0);

      // OP_W=16 sign-exact extremes
      s_wr_valid = 1;
      s_addr = 3'd2;
      s_opc = PASSA;
      s_a = -16'sd32768;
      s_b = 16'sd32767;
      tick();
      s_wr_valid = 0;
      s_rd_req = 1;
      tick();
      s_rd_req = 0;
      check("w16_word", s_word, w16(PASSA, -32768, 32767));
      check("w16_ev", s_entry_valid, 1);

      // Asynchronous reset mid-stream
      f_set(1, ADD, 60, 61, 0);
      r_op(0, 0, ZERO, 0, 0, 0, 0);
      r_op(1, 4, DIV, 8, 8, 0, 0);
      r_rd_req = 1;
      r_rd_addr = 5'd4;
      tick();
      r_rd_req = 0;
      f_set(0, ZERO, 0, 0, 0);
      check("pre_rst_rv", r_rd_valid, 1);
      #2;
      reset_n = 0;
      #1;
      check("arst_r_rv", r_rd_valid, 0);
      check("arst_r_word", r_word, 0);
      check("arst_r_count", r_count, 0);
      check("arst_f_count", f_count, 0);
      check("arst_f_empty", f_empty, 1);
      check("arst_f_full", f_full, 0);
      check("arst_s_word", s_word, 0);
      #3;
      reset_n = 1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
